// File: rtl/lzc.sv
// rtl/lzc.sv - registered leading/trailing zero counter built as a binary selection tree
// MODE=1 bit-reverses the input so a single lowest-set-bit tree serves both modes.
module lzc #(
  parameter int   WIDTH = 2,
  parameter logic MODE  = 1'b0,
  localparam int  CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     in_i,
  output logic [CNT_WIDTH-1:0] cnt_o,
  output logic                 empty_o
);

  localparam int LEVELS = CNT_WIDTH;
  localparam int NLEAF  = 2 ** LEVELS;

  logic [NLEAF-1:0]     vec;
  logic                 valid_t [LEVELS+1][NLEAF];
  logic [CNT_WIDTH-1:0] idx_t   [LEVELS+1][NLEAF];
  logic [CNT_WIDTH-1:0] cnt_next;
  logic                 empty_next;

  // Leaves past WIDTH are tied low so the padded tree never reports them.
  for (genvar i = 0; i < NLEAF; i++) begin : g_leaf
    if (i < WIDTH) begin : g_in
      assign vec[i] = MODE ? in_i[WIDTH-1-i] : in_i[i];
    end else begin : g_pad
      assign vec[i] = 1'b0;
    end
    assign valid_t[0][i] = vec[i];
    assign idx_t[0][i]   = '0;
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    for (genvar k = 0; k < NLEAF; k++) begin : g_node
      if (k < (NLEAF >> (l + 1))) begin : g_used
        assign valid_t[l+1][k] = valid_t[l][2*k] | valid_t[l][2*k+1];
        assign idx_t[l+1][k]   = valid_t[l][2*k] ? idx_t[l][2*k]
                                 : (idx_t[l][2*k+1] | CNT_WIDTH'(1 << l));
      end else begin : g_unused
        assign valid_t[l+1][k] = 1'b0;
        assign idx_t[l+1][k]   = '0;
      end
    end
  end

  assign empty_next = ~valid_t[LEVELS][0];
  assign cnt_next   = empty_next ? '0 : idx_t[LEVELS][0];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o   <= '0;
      empty_o <= 1'b1;
    end else begin
      cnt_o   <= cnt_next;
      empty_o <= empty_next;
    end
  end

endmodule

// File: tb/tb_lzc.sv
// tb/tb_lzc.sv - directed and model-checked bench for lzc across widths and modes
module tb_lzc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  a8_0, a8_1;
  logic [4:0]  a5;
  logic [3:0]  a4_0, a4_1;
  logic [63:0] a64_0, a64_1;
  logic        a1;
  logic [2:0]  c8_0, c8_1, c5;
  logic [1:0]  c4_0, c4_1;
  logic [5:0]  c64_0, c64_1;
  logic        c1;
  logic        e8_0, e8_1, e5, e4_0, e4_1, e64_0, e64_1, e1;

  int checks = 0;
  int errors = 0;

  lzc #(.WIDTH(8),  .MODE(1'b0)) u8_0  (.clk_i(clk), .rst_i(rst), .in_i(a8_0),  .cnt_o(c8_0),  .empty_o(e8_0));
  lzc #(.WIDTH(8),  .MODE(1'b1)) u8_1  (.clk_i(clk), .rst_i(rst), .in_i(a8_1),  .cnt_o(c8_1),  .empty_o(e8_1));
  lzc #(.WIDTH(5),  .MODE(1'b0)) u5    (.clk_i(clk), .rst_i(rst), .in_i(a5),    .cnt_o(c5),    .empty_o(e5));
  lzc #(.WIDTH(4),  .MODE(1'b0)) u4_0  (.clk_i(clk), .rst_i(rst), .in_i(a4_0),  .cnt_o(c4_0),  .empty_o(e4_0));
  lzc #(.WIDTH(4),  .MODE(1'b1)) u4_1  (.clk_i(clk), .rst_i(rst), .in_i(a4_1),  .cnt_o(c4_1),  .empty_o(e4_1));
  lzc #(.WIDTH(64), .MODE(1'b0)) u64_0 (.clk_i(clk), .rst_i(rst), .in_i(a64_0), .cnt_o(c64_0), .empty_o(e64_0));
  lzc #(.WIDTH(64), .MODE(1'b1)) u64_1 (.clk_i(clk), .rst_i(rst), .in_i(a64_1), .cnt_o(c64_1), .empty_o(e64_1));
  lzc #(.WIDTH(1),  .MODE(1'b0)) u1    (.clk_i(clk), .rst_i(rst), .in_i(a1),    .cnt_o(c1),    .empty_o(e1));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Straightforward scan used as the reference.
  function automatic int ref_cnt(input logic [63:0] v, input int w, input bit m);
    int c = 0;
    bit found = 1'b0;
    if (!m) begin
      for (int i = 0; i < w; i++)
        if (v[i] && !found) begin c = i; found = 1'b1; end
    end else begin
      for (int i = w - 1; i >= 0; i--)
        if (v[i] && !found) begin c = w - 1 - i; found = 1'b1; end
    end
    return c;
  endfunction

  function automatic bit ref_empty(input logic [63:0] v, input int w);
    bit e = 1'b1;
    for (int i = 0; i < w; i++)
      if (v[i]) e = 1'b0;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] rnd64(input int i);
    logic [63:0] v = {$urandom, $urandom};
    case (i % 4)
      1: v = v << $urandom_range(0, 63);
      2: v = v >> $urandom_range(0, 63);
      3: v = (i % 8 == 3) ? 64'd0 : (64'd1 << $urandom_range(0, 63));
      default: ;
    endcase
    return v;
  endfunction

  initial begin
    a8_0 = 0; a8_1 = 0; a5 = 0; a4_0 = 0; a4_1 = 0; a64_0 = 0; a64_1 = 0; a1 = 0;
    #12;
    check("rst_cnt8", 64'(c8_0), 0);
    check("rst_empty8", 64'(e8_0), 1);
    tick();
    check("rst_hold_cnt64", 64'(c64_1), 0);
    check("rst_hold_empty64", 64'(e64_1), 1);
    rst = 1'b0;

    a8_0 = 8'b0110_1000; a8_1 = 8'b0001_0110; a5 = 5'b10000; a1 = 1'b1;
    tick();
    check("m0_68_cnt", 64'(c8_0), 3);
    check("m0_68_empty", 64'(e8_0), 0);
    check("m1_16_cnt", 64'(c8_1), 3);
    check("w5_10000_cnt", 64'(c5), 4);
    check("w1_one_cnt", 64'(c1), 0);
    check("w1_one_empty", 64'(e1), 0);

    a8_0 = 8'h01; a8_1 = 8'h80; a5 = 5'b00000; a1 = 1'b0;
    tick();
    check("m0_01_cnt", 64'(c8_0), 0);
    check("m1_80_cnt", 64'(c8_1), 0);
    check("w5_zero_empty", 64'(e5), 1);
    check("w1_zero_empty", 64'(e1), 1);

    a8_0 = 8'h80; a8_1 = 8'h01;
    tick();
    check("m0_80_cnt", 64'(c8_0), 7);
    check("m1_01_cnt", 64'(c8_1), 7);

    a8_0 = 8'h00; a8_1 = 8'h00;
    tick();
    check("m0_zero_cnt", 64'(c8_0), 0);
    check("m0_zero_empty", 64'(e8_0), 1);
    check("m1_zero_cnt", 64'(c8_1), 0);
    check("m1_zero_empty", 64'(e8_1), 1);

    a8_0 = 8'hFF; a8_1 = 8'hFF;
    tick();
    check("m0_ff_cnt", 64'(c8_0), 0);
    check("m0_ff_empty", 64'(e8_0), 0);
    check("m1_ff_cnt", 64'(c8_1), 0);
    check("m1_ff_empty", 64'(e8_1), 0);

    for (int v = 0; v < 32; v++) begin
      a5 = 5'(v);
      tick();
      check("w5_sweep_cnt", 64'(c5), 64'(ref_cnt(64'(v), 5, 1'b0)));
      check("w5_sweep_empty", 64'(e5), 64'(ref_empty(64'(v), 5)));
    end

    // Asynchronous reset between edges, with a pending non-zero result.
    a8_0 = 8'h80;
    tick();
    check("pre_rst_cnt", 64'(c8_0), 7);
    a8_0 = 8'h02;
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_cnt", 64'(c8_0), 0);
    check("async_rst_empty", 64'(e8_0), 1);
    tick();
    check("rst_held_cnt", 64'(c8_0), 0);
    rst = 1'b0;
    a8_0 = 8'h20;
    tick();
    check("post_rst_cnt", 64'(c8_0), 5);
    check("post_rst_empty", 64'(e8_0), 0);

    for (int i = 0; i < 1000; i++) begin
      logic [63:0] r0, r1, r2, r3;
      r0 = rnd64(i); r1 = rnd64(i + 1); r2 = rnd64(i); r3 = rnd64(i + 2);
      a4_0 = r0[3:0]; a4_1 = r1[3:0]; a64_0 = r2; a64_1 = r3;
      tick();
      check("rnd_w4m0_cnt", 64'(c4_0), 64'(ref_cnt(r0, 4, 1'b0)));
      check("rnd_w4m0_empty", 64'(e4_0), 64'(ref_empty(r0, 4)));
      check("rnd_w4m1_cnt", 64'(c4_1), 64'(ref_cnt(r1, 4, 1'b1)));
      check("rnd_w4m1_empty", 64'(e4_1), 64'(ref_empty(r1, 4)));
      check("rnd_w64m0_cnt", 64'(c64_0), 64'(ref_cnt(r2, 64, 1'b0)));
      check("rnd_w64m0_empty", 64'(e64_0), 64'(ref_empty(r2, 64)));
      check("rnd_w64m1_cnt", 64'(c64_1), 64'(ref_cnt(r3, 64, 1'b1)));
      check("rnd_w64m1_empty", 64'(e64_1), 64'(ref_empty(r3, 64)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
